// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one combinational ALU between
// the execute stage (port 0) and the branch/compare unit (port 1). One
// operation is in flight at a time: IDLE -> EXEC -> RESP -> IDLE. An
// unsupported control code goes IDLE -> RESP and returns an error response.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 6,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [CTRL_W-1:0] req_ctrl0,
   input  logic [CTRL_W-1:0] req_ctrl1,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [DATA_W-1:0] req_b1,
   output logic [CTRL_W-1:0] alu_control,
   output logic [DATA_W-1:0] alu_read1,
   output logic [DATA_W-1:0] alu_foutput,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [DATA_W-1:0] rsp_out,
   output logic              rsp_zero,
   output logic              rsp_overflow,
   output logic              rsp_err,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_d;

   logic              rr_pri;
   logic              grant;
   logic [CTRL_W-1:0] lat_ctrl;
   logic [DATA_W-1:0] lat_a;
   logic [DATA_W-1:0] lat_b;

   logic              win;
   logic              accept;
   logic              rsp_hs;
   logic [CTRL_W-1:0] sel_ctrl;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic              sel_legal;

   // Control codes the attached ALU actually implements.
   function automatic logic is_legal(input logic [CTRL_W-1:0] c);
      case (c)
         CTRL_W'(1),  CTRL_W'(4),  CTRL_W'(5),  CTRL_W'(8),
         CTRL_W'(10), CTRL_W'(12), CTRL_W'(13), CTRL_W'(14),
         CTRL_W'(32), CTRL_W'(34), CTRL_W'(36), CTRL_W'(37),
         CTRL_W'(39), CTRL_W'(42): is_legal = 1'b1;
         default:                  is_legal = 1'b0;
      endcase
   endfunction

   // Arbitration winner: the lone valid requester, or rr_pri when both ask.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      win = 1'b0;
      if (req_valid == 2'b11)
         win = rr_pri;
      else if (req_valid[1])
         win = 1'b1;
      sel_ctrl  = win ? req_ctrl1 : req_ctrl0;
      sel_a     = win ? req_a1    : req_a0;
      sel_b     = win ? req_b1    : req_b0;
      sel_legal = is_legal(sel_ctrl);
   end

   assign accept    = (state == IDLE) && (|req_valid);
   assign rsp_hs    = (state == RESP) && rsp_ready[grant];
   assign req_ready = accept ? (2'b01 << win) : 2'b00;
   assign rsp_valid = (state == RESP) ? (2'b01 << grant) : 2'b00;
   assign busy      = (state != IDLE);

   // The ALU only sees the latched operands, and only during EXEC.
   assign alu_control = (state == EXEC) ? lat_ctrl : '0;
   assign alu_read1   = (state == EXEC) ? lat_a    : '0;
   assign alu_foutput = (state == EXEC) ? lat_b    : '0;

   // Next-state logic for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept) state_d = sel_legal ? EXEC : RESP;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; an async reset drops any in-flight operation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= state_d;
   end

   // Request latch, result capture, round-robin pointer and op counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the operand latches are reset too; they are few flops, not a memory, and keep the ALU bus deterministic.
         rr_pri       <= 1'b0;
         grant        <= 1'b0;
         lat_ctrl     <= '0;
         lat_a        <= '0;
         lat_b        <= '0;
         rsp_out      <= '0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_err      <= 1'b0;
         op_count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  grant    <= win;
                  lat_ctrl <= sel_ctrl;
                  lat_a    <= sel_a;
                  lat_b    <= sel_b;
                  if (!sel_legal) begin
                     rsp_out      <= '0;
                     rsp_zero     <= 1'b0;
                     rsp_overflow <= 1'b0;
                     rsp_err      <= 1'b1;
                  end
               end
            end
            EXEC: begin
               rsp_out      <= alu_out;
               rsp_zero     <= alu_zero;
               rsp_overflow <= alu_overflow;
               rsp_err      <= 1'b0;
            end
            RESP: begin
               if (rsp_hs) begin
                  rr_pri <= ~grant;
                  if (op_count != {CNT_W{1'b1}})
                     op_count <= op_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU model attached
// to the ALU port. CNT_W is shrunk to 4 so counter saturation is reachable.
module tb_alu_arbiter;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 6;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [CTRL_W-1:0] req_ctrl0, req_ctrl1;
   logic [DATA_W-1:0] req_a0, req_a1, req_b0, req_b1;
   logic [CTRL_W-1:0] alu_control;
   logic [DATA_W-1:0] alu_read1, alu_foutput;
   logic [DATA_W-1:0] alu_out;
   logic              alu_zero, alu_overflow;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [DATA_W-1:0] rsp_out;
   logic              rsp_zero, rsp_overflow, rsp_err, busy;
   logic [CNT_W-1:0]  op_count;

   int checks = 0;
   int failures = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
      .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
      .alu_control(alu_control), .alu_read1(alu_read1), .alu_foutput(alu_foutput),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
      .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
   );

   // Behavioural ALU: add/sub/and/or/nor/slt plus beq/bne zero flag.
   always_comb begin
      alu_out      = '0;
      alu_overflow = 1'b0;
      case (alu_control)
         6'd32: {alu_overflow, alu_out} = {1'b0, alu_read1} + {1'b0, alu_foutput};
         6'd34, 6'd4, 6'd5: alu_out = alu_read1 - alu_foutput;
         6'd36: alu_out = alu_read1 & alu_foutput;
         6'd37: alu_out = alu_read1 | alu_foutput;
         6'd39: alu_out = ~(alu_read1 | alu_foutput);
         6'd42: alu_out = {31'd0, $signed(alu_read1) < $signed(alu_foutput)};
         default: alu_out = '0;
      endcase
      if (alu_control == 6'd4)
         alu_zero = (alu_read1 == alu_foutput);
      else if (alu_control == 6'd5)
         alu_zero = (alu_read1 != alu_foutput);
      else
         alu_zero = (alu_out == '0);
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [1:0] onehot(input int p);
      return (p == 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic void bump_cnt();
      if (exp_cnt < 15) exp_cnt++;
   endfunction

   // One complete single-requester operation with its expected result.
   task automatic do_op(input int p, input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic legal, input logic [31:0] e_out,
                        input logic e_zero, input logic e_ovf, input logic e_err);
      @(negedge clk);
      req_valid = onehot(p);
      if (p == 0) begin req_ctrl0 = c; req_a0 = a; req_b0 = b; end
      else        begin req_ctrl1 = c; req_a1 = a; req_b1 = b; end
      #1;
      check("req_ready", req_ready, onehot(p));
      check("idle_alu_ctrl", alu_control, 0);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      if (legal) begin
         @(negedge clk);
         check("exec_ctrl", alu_control, c);
         check("exec_read1", alu_read1, a);
         check("exec_fout", alu_foutput, b);
         check("exec_rsp_valid", rsp_valid, 0);
      end
      @(negedge clk);
      check("rsp_valid", rsp_valid, onehot(p));
      check("rsp_out", rsp_out, e_out);
      check("rsp_zero", rsp_zero, e_zero);
      check("rsp_ovf", rsp_overflow, e_ovf);
      check("rsp_err", rsp_err, e_err);
      check("resp_alu_ctrl", alu_control, 0);
      rsp_ready = onehot(p);
      @(posedge clk);
      #1;
      rsp_ready = 2'b00;
      bump_cnt();
      check("rsp_valid_clr", rsp_valid, 0);
      check("busy_clr", busy, 0);
      check("op_count", op_count, exp_cnt);
   endtask

   // Both requesters valid: check the winner and result; optional RESP stall.
   task automatic rr_op(input int g, input logic [5:0] c, input logic [31:0] e_out,
                        input int stall);
      @(negedge clk);
      req_valid = 2'b11;
      req_ctrl0 = c; req_ctrl1 = c;
      req_a0 = 32'hF0F0_00FF; req_a1 = 32'hF0F0_00FF;
      req_b0 = 32'h0FF0_0F0F; req_b1 = 32'h0FF0_0F0F;
      #1;
      check("rr_ready", req_ready, onehot(g));
      @(negedge clk);
      check("rr_exec_ready", req_ready, 0);
      @(negedge clk);
      check("rr_rsp_valid", rsp_valid, onehot(g));
      check("rr_rsp_out", rsp_out, e_out);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_valid", rsp_valid, onehot(g));
         check("stall_out", rsp_out, e_out);
         check("stall_ready", req_ready, 0);
      end
      rsp_ready = 2'b11;
      @(posedge clk);
      #1;
      rsp_ready = 2'b00;
      bump_cnt();
      check("rr_op_count", op_count, exp_cnt);
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_ctrl0 = '0; req_ctrl1 = '0;
      req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_op_count", op_count, 0);
      check("rst_alu_ctrl", alu_control, 0);
      check("rst_rsp_out", rsp_out, 0);
      check("rst_rsp_err", rsp_err, 0);
      @(negedge clk);
      reset_n = 1'b1;

      do_op(0, 6'd32, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
      do_op(1, 6'd32, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0);
      do_op(1, 6'd4, 32'd9, 32'd9, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
      do_op(1, 6'd5, 32'd9, 32'd9, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);

      rr_op(0, 6'd36, 32'h00F0_000F, 3);
      rr_op(1, 6'd37, 32'hFFF0_0FFF, 0);
      rr_op(0, 6'd34, 32'hE0FF_F1F0, 0);
      rr_op(1, 6'd42, 32'd1, 0);
      @(negedge clk);
      req_valid = 2'b00;

      do_op(0, 6'd33, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

      // Async reset while in EXEC.
      @(negedge clk);
      req_valid = 2'b01; req_ctrl0 = 6'd32; req_a0 = 32'd1; req_b0 = 32'd2;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("pre_rst_exec", alu_control, 32);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_alu_ctrl", alu_control, 0);
      check("arst_read1", alu_read1, 0);
      check("arst_busy", busy, 0);
      check("arst_op_count", op_count, 0);
      check("arst_rsp_out", rsp_out, 0);
      exp_cnt = 0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_rsp", rsp_valid, 0);
      end

      // Drive the counter to all-ones, then one more op must not wrap.
      for (int i = 0; i < 16; i++)
         do_op(i % 2, 6'd37, 32'h0000_0F00, 32'h0000_00F0, 1'b1, 32'h0000_0FF0,
               1'b0, 1'b0, 1'b0);
      check("sat_count", op_count, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
